// File: rtl/rgmii_idelay_pkg.sv
// Shared definitions for the RGMII receive IDELAY sequencer: state encoding
// and lane-slice helpers.
package rgmii_idelay_pkg;

  typedef enum logic [2:0] {
    PHY_RST  = 3'd0,
    PHY_WAIT = 3'd1,
    WAIT_RDY = 3'd2,
    LOAD     = 3'd3,
    SETTLE   = 3'd4,
    IDLE     = 3'd5
  } state_t;

  // Bit offset of a lane field inside a packed multi-lane tap bus.
  function automatic int lane_lsb(input int lane, input int tap_w);
    return lane * tap_w;
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sync_signal.sv
// N-stage flop synchronizer for asynchronous level inputs.
module sync_signal #(
  parameter int WIDTH = 1,
  parameter int N     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] sync_r [N];

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= in;
      for (int i = 1; i < N; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign out = sync_r[N-1];

endmodule

// File: rtl/rgmii_idelay_seq.sv
// PHY reset / IDELAYE2 VAR_LOAD tap sequencer for the RGMII receive lanes.
// Optional readback check of CNTVALUEOUT enabled by defining RIDELAY_VERIFY_EN.
module rgmii_idelay_seq
  import rgmii_idelay_pkg::*;
#(
  parameter int LANES        = 5,
  parameter int TAP_W        = 5,
  parameter int RESET_CYCLES = 16,
  parameter int RESET_WAIT   = 8,
  parameter int DEFAULT_TAP  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   idelayctrl_rdy,
  input  logic [LANES*TAP_W-1:0] cfg_tap,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic [LANES*TAP_W-1:0] dly_cntvaluein,
  output logic [LANES-1:0]       dly_ld,
  input  logic [LANES*TAP_W-1:0] dly_cntvalueout,
  output logic                   phy_reset_n,
  output logic [LANES*TAP_W-1:0] cur_tap,
  output logic                   done,
  output logic                   error
);

  localparam int BUS_W  = LANES * TAP_W;
  localparam int CNT_W  = cnt_width(RESET_CYCLES, RESET_WAIT);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BUS_W-1:0]  DEFAULT_BUS = {LANES{TAP_W'(DEFAULT_TAP)}};
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [LANE_W-1:0]  lane_r;
  logic [LANE_W-1:0]  next_lane_s;
  logic [BUS_W-1:0]   pending_r;
  logic               rdy_lost_r;
  logic               load_bad_r;
  logic               rdy_sync_s;
  logic               mismatch_s;

  sync_signal #(.WIDTH(1), .N(2)) u_rdy_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .in    (idelayctrl_rdy),
    .out   (rdy_sync_s)
  );

  assign next_lane_s = lane_r + LANE_W'(1);
  assign cfg_ready   = (state_r == IDLE) && rdy_sync_s;

`ifdef RIDELAY_VERIFY_EN
  // In SETTLE the written value is still on dly_cntvaluein, so compare against it.
  assign mismatch_s = (state_r == SETTLE) &&
      (dly_cntvalueout[lane_lsb(int'(lane_r), TAP_W) +: TAP_W] !=
       dly_cntvaluein[lane_lsb(int'(lane_r), TAP_W) +: TAP_W]);
`else
  logic unused_readback;
  assign unused_readback = ^dly_cntvalueout;
  assign mismatch_s      = 1'b0;
`endif

  // Sequencer FSM with all control outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= PHY_RST;
      cnt_r          <= CNT_W'(RESET_CYCLES - 1);
      lane_r         <= '0;
      pending_r      <= DEFAULT_BUS;
      rdy_lost_r     <= 1'b0;
      load_bad_r     <= 1'b0;
      phy_reset_n    <= 1'b0;
      dly_ld         <= '0;
      dly_cntvaluein <= DEFAULT_BUS;
      cur_tap        <= DEFAULT_BUS;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      case (state_r)
        PHY_RST: begin
          if (cnt_r == '0) begin
            state_r     <= PHY_WAIT;
            phy_reset_n <= 1'b1;
            cnt_r       <= CNT_W'(RESET_WAIT - 1);
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        PHY_WAIT: begin
          if (cnt_r == '0) state_r <= WAIT_RDY;
          else             cnt_r   <= cnt_r - CNT_W'(1);
        end
        WAIT_RDY: begin
          if (rdy_sync_s) begin
            state_r                    <= LOAD;
            lane_r                     <= '0;
            rdy_lost_r                 <= 1'b0;
            load_bad_r                 <= 1'b0;
            dly_ld                     <= LANES'(1);
            dly_cntvaluein[TAP_W-1:0]  <= pending_r[TAP_W-1:0];
          end
        end
        LOAD: begin
          state_r <= SETTLE;
          dly_ld  <= '0;
          if (!rdy_sync_s) rdy_lost_r <= 1'b1;
        end
        SETTLE: begin
          if (mismatch_s) begin
            error      <= 1'b1;
            load_bad_r <= 1'b1;
          end
          if (lane_r == LAST_LANE) begin
            cur_tap <= pending_r;
            if (!load_bad_r && !mismatch_s) error <= 1'b0;
            // A RDY drop seen anywhere in the load forces a reload of the same set.
            if (rdy_lost_r || !rdy_sync_s) begin
              state_r <= WAIT_RDY;
            end else begin
              state_r <= IDLE;
              done    <= 1'b1;
            end
          end else begin
            if (!rdy_sync_s) rdy_lost_r <= 1'b1;
            state_r <= LOAD;
            lane_r  <= next_lane_s;
            dly_ld  <= LANES'(1) << next_lane_s;
            dly_cntvaluein[lane_lsb(int'(next_lane_s), TAP_W) +: TAP_W] <=
                pending_r[lane_lsb(int'(next_lane_s), TAP_W) +: TAP_W];
          end
        end
        IDLE: begin
          if (!rdy_sync_s) begin
            state_r   <= WAIT_RDY;
            done      <= 1'b0;
            pending_r <= cur_tap;
          end else if (cfg_valid) begin
            state_r                   <= LOAD;
            done                      <= 1'b0;
            pending_r                 <= cfg_tap;
            lane_r                    <= '0;
            rdy_lost_r                <= 1'b0;
            load_bad_r                <= 1'b0;
            dly_ld                    <= LANES'(1);
            dly_cntvaluein[TAP_W-1:0] <= cfg_tap[TAP_W-1:0];
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state_r <= PHY_RST;
          cnt_r   <= CNT_W'(RESET_CYCLES - 1);
          dly_ld  <= '0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rgmii_idelay_seq.md
# rgmii_idelay_seq

Bring-up and runtime sequencer for the RGMII receive input-delay path on the Nexys Video Ethernet port. It holds the PHY in reset for a fixed interval and waits for the IDELAY reference controller to report ready. It then loads a tap value into each receive-lane IDELAYE2, which run in VAR_LOAD mode. Afterwards it accepts new tap sets from the control plane through a valid/ready handshake. It sits in the top level, between the 125 MHz clock/reset logic and the delay primitives feeding fpga_core.

## Interface
- LANES, 5: number of delay lanes (rxd[3:0] plus rx_ctl); lane i occupies bits [i*TAP_W +: TAP_W].
- TAP_W, 5: tap value width.
- RESET_CYCLES, 16: cycles phy_reset_n is held low after reset release; must be ≥1.
- RESET_WAIT, 8: cycles waited after phy_reset_n rises; must be ≥1.
- DEFAULT_TAP, 0: tap loaded into every lane at bring-up.
- clk  in  1  125 MHz system clock; also drives IDELAYE2 C.
- reset_n  in  1  asynchronous, active-low reset.
- idelayctrl_rdy  in  1  IDELAYCTRL RDY; asynchronous, synchronized internally.
- cfg_tap  in  LANES*TAP_W  requested taps.
- cfg_valid  in  1  request to apply cfg_tap.
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
- dly_cntvaluein  out  LANES*TAP_W  to IDELAYE2 CNTVALUEIN.
- dly_ld  out  LANES  per-lane IDELAYE2 LD strobe.
- dly_cntvalueout  in  LANES*TAP_W  from IDELAYE2 CNTVALUEOUT.
- phy_reset_n  out  1  PHY reset, active low.
- cur_tap  out  LANES*TAP_W  last committed tap set.
- done  out  1  all lanes loaded and RDY high.
- error  out  1  readback mismatch, sticky (RIDELAY_VERIFY_EN only).

## Operation
- States:
  - PHY_RST: phy_reset_n=0; runs for RESET_CYCLES, then goes to PHY_WAIT.
  - PHY_WAIT: phy_reset_n=1; runs for RESET_WAIT, then goes to WAIT_RDY.
  - WAIT_RDY: waits for the synchronized RDY, then goes to LOAD with lane=0.
  - LOAD: one LD cycle followed by one SETTLE cycle per lane; after lane LANES-1, goes to IDLE.
  - IDLE: steady state; exits on a new request or on RDY loss.
- Tap sources:
  - Bring-up load uses DEFAULT_TAP in every lane.
  - A handshake loads the pending set captured from cfg_tap.
  - A reload after RDY loss reuses cur_tap.
- LD cycle: dly_cntvaluein lane field = pending tap; dly_ld[lane]=1 for exactly one cycle; all other dly_ld bits are 0. dly_cntvaluein holds its value through SETTLE.
- cfg_ready = (state==IDLE) && rdy_sync. This is the only cycle in which cfg_tap is captured.
- cur_tap updates to the pending set when LOAD completes. done=1 only in IDLE.
- RDY loss in IDLE: go to WAIT_RDY, then reload cur_tap. A RDY drop during LOAD does not abort the load; after it finishes, the block re-enters WAIT_RDY and reloads.
- Simultaneous cfg_valid and RDY drop: RDY loss wins and the request is not accepted (cfg_ready is already 0).
- Counters: a single down-counter of width $clog2(max(RESET_CYCLES,RESET_WAIT)+1), plus a lane index of width $clog2(LANES).

## Timing
- All outputs are registered, except cfg_ready (decode of registered state plus rdy_sync).
- Reset values:
  - phy_reset_n=0, dly_ld=0, done=0, error=0.
  - dly_cntvaluein = DEFAULT_TAP in all lanes; cur_tap = DEFAULT_TAP in all lanes.
  - State PHY_RST.
- Reset assertion mid-operation forces reset values immediately (asynchronous). No partial load is retained.
- RDY synchronizer: 2 flops, adding 2 cycles of latency.
- Bring-up, RDY already high: phy_reset_n rises at cycle RESET_CYCLES after reset release. dly_ld[0] pulses at RESET_CYCLES+RESET_WAIT+1 (+2 for the synchronizer on first use). done rises 2*LANES cycles after the dly_ld[0] pulse.
- Handshake to dly_ld[0]: 1 cycle. Handshake to done: 2*LANES+1 cycles.

## Configuration
- RIDELAY_VERIFY_EN defined:
  - In each SETTLE cycle, compare dly_cntvalueout lane to the value written.
  - Any mismatch sets error.
  - error clears when a full LOAD completes with no mismatch.
- Undefined: dly_cntvalueout is ignored and error is tied 0. Cycle timing is identical in both builds.

## Structure
- Shared package rgmii_idelay_pkg holds the state encoding localparams (PHY_RST, PHY_WAIT, WAIT_RDY, LOAD, SETTLE, IDLE) and the lane-slice width helper.
- RDY synchronization uses the existing sync_signal module (WIDTH=1, N=2). No other sub-module.

## Test plan
All scenarios use LANES=5, TAP_W=5, RESET_CYCLES=16, RESET_WAIT=8, DEFAULT_TAP=0.
- Reset release, RDY=1:
  - phy_reset_n low for exactly 16 cycles.
  - Five single-cycle dly_ld pulses on lanes 0→4, 2 cycles apart, all with value 0.
  - done=1, cur_tap=0.
- RDY held 0 for 100 cycles after PHY_WAIT: no dly_ld activity and done=0; loading starts 3 cycles after RDY rises.
- In IDLE, cfg_tap={31,20,12,7,3} (lane4..0) with a one-cycle cfg_valid:
  - Lanes load 3,7,12,20,31.
  - cfg_ready stays low for 10 cycles.
  - cur_tap updates on completion.
- RDY drop in IDLE, together with cfg_valid:
  - Request rejected and done falls.
  - After RDY returns, the previous cur_tap is reloaded.
- RIDELAY_VERIFY_EN, lane 2 readback forced to 5 against a written 12: error=1. The next clean load clears error.
- reset_n asserted during the LD cycle of lane 3: dly_ld=0 and phy_reset_n=0 immediately. A full bring-up sequence follows release.
